// File: rtl/network_sequencer.sv
// Host-side sequencer: byte-streams an image into the pixel vector, starts
// the network, waits out the run window and hands back one result word.
module network_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 784,
  parameter int SETTLE = 2,
  parameter int BAL_W  = $clog2(HEIGHT*(2**WIDTH-1)+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HEIGHT-1:0] net_pixels,
  output logic              net_start,
  input  logic [1:0]        net_out,
  input  logic [BAL_W-1:0]  net_balance,
  output logic [BAL_W+1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int NBYTES     = (HEIGHT+7)/8;
  localparam int RUN_CYCLES = HEIGHT*(2**(WIDTH+1)+2);
  localparam int RUN_LAST   = RUN_CYCLES+SETTLE-1;
  localparam int BC_W       = $clog2(NBYTES+1);
  localparam int RC_W       = $clog2(RUN_CYCLES+SETTLE+1);

  typedef enum logic [1:0] {
    LOAD,
    START,
    RUN,
    REPORT
  } state_t;

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic [HEIGHT-1:0]   pix_q, pix_d;
  logic [BAL_W+1:0]    res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      pix_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      pix_q   <= pix_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    pix_d   = pix_q;
    res_d   = res_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          // Byte k lands MSB-first at pixel HEIGHT-1-8k; overflow bits drop.
          for (int j = 0; j < HEIGHT; j++) begin
            if (BC_W'(j/8) == bcnt_q)
              pix_d[HEIGHT-1-j] = in_data[7-(j%8)];
          end
          if (bcnt_q == BC_W'(NBYTES-1)) begin
            bcnt_d  = '0;
            state_d = START;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      START: begin
        rcnt_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RC_W'(RUN_LAST)) begin
          res_d   = {net_out, net_balance};
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready)
          state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign in_ready   = (state_q == LOAD);
  assign net_start  = (state_q == START);
  assign res_valid  = (state_q == REPORT);
  assign busy       = !((state_q == LOAD) && (bcnt_q == '0));
  assign net_pixels = pix_q;
  assign res_data   = res_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: one-byte (HEIGHT=7) and
// two-byte (HEIGHT=12) instances sharing clock and reset.
module tb_network_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] in_data;
  logic       in_valid, in_ready, net_start, res_valid, res_ready, busy;
  logic [6:0] net_pixels;
  logic [1:0] net_out;
  logic [7:0] net_balance;
  logic [9:0] res_data;

  logic [7:0]  in_data2;
  logic        in_valid2, in_ready2, net_start2, res_valid2, res_ready2, busy2;
  logic [11:0] net_pixels2;
  logic [1:0]  net_out2;
  logic [7:0]  net_balance2;
  logic [9:0]  res_data2;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  network_sequencer #(.WIDTH(2), .HEIGHT(7), .SETTLE(2), .BAL_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .net_pixels(net_pixels), .net_start(net_start),
    .net_out(net_out), .net_balance(net_balance),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  network_sequencer #(.WIDTH(2), .HEIGHT(12), .SETTLE(2), .BAL_W(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .net_pixels(net_pixels2), .net_start(net_start2),
    .net_out(net_out2), .net_balance(net_balance2),
    .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready2),
    .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || net_start !== 1'b0 || res_valid !== 1'b0 ||
        busy !== 1'b0 || res_data !== 10'd0 || net_pixels !== 7'd0) begin
      fails++;
      $display("FAIL reset: rdy=%b st=%b rv=%b busy=%b rd=%h px=%b want 1 0 0 0 000 0000000",
               in_ready, net_start, res_valid, busy, res_data, net_pixels);
    end
    checks++;
    if (in_ready2 !== 1'b1 || busy2 !== 1'b0 || net_pixels2 !== 12'h000) begin
      fails++;
      $display("FAIL reset2: rdy=%b busy=%b px=%h want 1 0 000",
               in_ready2, busy2, net_pixels2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_image();
    int n;
    in_data  = 8'b1011_0011;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (net_start !== 1'b1 || net_pixels !== 7'b1011001 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_start: st=%b px=%b rdy=%b want 1 1011001 0",
               net_start, net_pixels, in_ready);
    end
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (net_start !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL start_pulse_width: st=%b busy=%b want 0 1", net_start, busy);
        end
      end
      if (n == 60) begin
        net_out     = 2'b01;
        net_balance = 8'd37;
      end
    end
    checks++;
    if (n != 73) begin
      fails++;
      $display("FAIL run_latency: got %0d cycles want 73", n);
    end
    checks++;
    if (res_data !== 10'b01_00100101 || net_pixels !== 7'b1011001) begin
      fails++;
      $display("FAIL result: rd=%b px=%b want 0100100101 1011001",
               res_data, net_pixels);
    end
  endtask

  task automatic test_report_hold();
    int bad;
    bad = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_data  = 8'h00;
      tick();
      if (res_valid !== 1'b1 || res_data !== 10'b01_00100101 ||
          in_ready !== 1'b0 || net_pixels !== 7'b1011001)
        bad++;
      net_balance = 8'd99;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL report_hold: %0d unstable cycles want 0", bad);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL report_accept: rv=%b rdy=%b busy=%b want 0 1 0",
               res_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    net_out     = 2'b00;
    net_balance = 8'd0;
    in_data     = 8'h55;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || net_start !== 1'b0 ||
        busy !== 1'b0 || net_pixels !== 7'd0) begin
      fails++;
      $display("FAIL reset_mid_run: rv=%b rdy=%b st=%b busy=%b px=%b want 0 1 0 0 0000000",
               res_valid, in_ready, net_start, busy, net_pixels);
    end
    tick();
    rst = 1'b0;
    tick();
    net_out     = 2'b10;
    net_balance = 8'd200;
    in_data     = 8'hF0;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (net_start !== 1'b1 || net_pixels !== 7'b1111000) begin
      fails++;
      $display("FAIL restart_load: st=%b px=%b want 1 1111000", net_start, net_pixels);
    end
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 73 || res_data !== 10'b10_11001000) begin
      fails++;
      $display("FAIL restart_result: lat=%0d rd=%b want 73 1011001000", n, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_two_byte();
    int n;
    net_out2     = 2'b01;
    net_balance2 = 8'd12;
    in_data2     = 8'hA5;
    in_valid2    = 1'b1;
    tick();
    checks++;
    if (net_start2 !== 1'b0 || in_ready2 !== 1'b1 || busy2 !== 1'b1) begin
      fails++;
      $display("FAIL two_byte_first: st=%b rdy=%b busy=%b want 0 1 1",
               net_start2, in_ready2, busy2);
    end
    in_data2 = 8'hC0;
    tick();
    in_valid2 = 1'b0;
    checks++;
    if (net_start2 !== 1'b1 || net_pixels2 !== 12'hA5C) begin
      fails++;
      $display("FAIL two_byte_second: st=%b px=%h want 1 A5C", net_start2, net_pixels2);
    end
    n = 0;
    while (res_valid2 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n != 123 || res_data2 !== 10'b01_00001100) begin
      fails++;
      $display("FAIL two_byte_result: lat=%0d rd=%b want 123 0100001100", n, res_data2);
    end
    res_ready2 = 1'b1;
    tick();
    res_ready2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int starts, nres, s0, s1, bad;
    starts = 0;
    nres   = 0;
    s0     = 0;
    s1     = 0;
    bad    = 0;
    net_out     = 2'b10;
    net_balance = 8'd200;
    res_ready   = 1'b1;
    in_data     = 8'hFE;
    in_valid    = 1'b1;
    for (int c = 0; c < 400 && nres < 2; c++) begin
      tick();
      if (net_start === 1'b1) begin
        starts++;
        if (starts == 1) begin
          s0 = cyc;
          if (net_pixels !== 7'b1111111) bad++;
          in_data = 8'h00;
        end else begin
          s1 = cyc;
          if (net_pixels !== 7'b0000000) bad++;
          in_valid = 1'b0;
        end
      end
      if (res_valid === 1'b1) begin
        nres++;
        if (nres == 1) begin
          if (res_data !== 10'b10_11001000) bad++;
          net_out     = 2'b11;
          net_balance = 8'd5;
        end else begin
          if (res_data !== 10'b11_00000101) bad++;
        end
      end
    end
    in_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    checks++;
    if (nres != 2 || starts != 2 || bad != 0) begin
      fails++;
      $display("FAIL b2b_results: res=%0d starts=%0d bad=%0d want 2 2 0",
               nres, starts, bad);
    end
    checks++;
    if (s1 - s0 < 75) begin
      fails++;
      $display("FAIL b2b_gap: got %0d cycles want >=75", s1 - s0);
    end
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: rdy=%b rv=%b want 1 0", in_ready, res_valid);
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    res_ready    = 1'b0;
    net_out      = 2'b00;
    net_balance  = 8'd0;
    in_data2     = 8'h00;
    in_valid2    = 1'b0;
    res_ready2   = 1'b0;
    net_out2     = 2'b00;
    net_balance2 = 8'd0;
    test_reset();
    test_single_image();
    test_report_hold();
    test_reset_mid_run();
    test_two_byte();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Host-side initiator for the run_network responder.
- Accepts a pixel image as a byte stream from the JTAG bridge and assembles it into the HEIGHT-bit pixel vector.
- Pulses start, waits a fixed run window, then samples the classification and balance.
- Returns one result word to the JTAG bridge through a valid/ready handshake. Sits between the JTAG register layer and the network instance.

Parameters:
- WIDTH, 8, weight magnitude width of the attached network; sets the run window.
- HEIGHT, 784, pixel count of the attached network.
- SETTLE, 2, extra clk cycles waited after the run window before sampling.
- NBYTES, (HEIGHT+7)/8 (derived), input bytes per image.
- RUN_CYCLES, HEIGHT*(2**(WIDTH+1)+2) (derived), network run window in clk cycles.
- BAL_W, $clog2(HEIGHT*(2**WIDTH-1)+1) (derived), balance width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  pixel byte; the first byte carries the most significant pixels.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- net_pixels  out  HEIGHT  pixel vector to the network; held stable from START until the end of RUN.
- net_start  out  1  active-high start pulse to the network.
- net_out  in  2  network class: 00 don't know, 01 pos, 10 neg.
- net_balance  in  BAL_W  network balance output.
- res_data  out  BAL_W+2  {net_out, net_balance} as sampled.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  consumer accepts res_data.
- busy  out  1  high in every state except LOAD with byte count 0.

Behaviour:
- Reset: state=LOAD, byte count=0, net_pixels=0, net_start=0, in_ready=1, res_valid=0, res_data=0, busy=0, run counter=0. Assertion at any time, including mid-RUN, returns to these values on the next evaluation.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, byte k (0-based) is written to net_pixels[HEIGHT-1-8k -: 8]. Bits that fall below index 0 on the last byte are discarded.
  - The count increments. The byte that brings the count to NBYTES moves the FSM to START next cycle and resets the count to 0.
  - net_pixels bits not yet written keep their previous image's values.
- START:
  - Lasts exactly one cycle; net_start=1, in_ready=0.
  - Next state is RUN with the run counter at 0.
- RUN:
  - net_start=0, in_ready=0.
  - The counter increments each cycle.
  - At count RUN_CYCLES+SETTLE-1, the FSM samples res_data<={net_out,net_balance}, sets res_valid=1 and moves to REPORT.
  - Total from START to res_valid rising is RUN_CYCLES+SETTLE+1 cycles.
- REPORT:
  - res_valid=1; res_data is held constant until the handshake.
  - On res_valid&res_ready: res_valid=0 next cycle and state returns to LOAD.
  - in_ready stays 0 in REPORT, so no overlap of the next image's load with an unread result.
- Handshake rules:
  - in_ready and res_valid never depend combinationally on in_valid or res_ready; both are registered state decodes.
  - res_valid never drops without res_ready.
- Counter widths: the run counter must hold RUN_CYCLES+SETTLE without wrap; the byte counter must hold NBYTES. No wrap-around is permitted in normal operation.
- in_valid asserted outside LOAD is ignored; the data is not consumed.
- A net_out value of 11 is illegal and is passed through unchanged; the sequencer does not check it.

Test Plan (HEIGHT=7, WIDTH=2, SETTLE=2 → NBYTES=1, RUN_CYCLES=70, BAL_W=8):
- Reset mid-RUN (cycle 30) → res_valid=0, in_ready=1, net_start=0, busy=0 next cycle; a following byte load restarts cleanly.
- Byte 8'b1011001x with in_valid → net_pixels=7'b1011001, LSB discarded; net_start high exactly 1 cycle, one cycle after the accept.
- Load as above; stub drives net_out=01, net_balance=8'd37 from cycle 60 → res_valid rises 73 cycles after START; res_data=10'b01_00100101.
- res_ready held low 20 cycles in REPORT → res_data and res_valid stable; in_valid pulses are ignored and in_ready=0; the accept on res_ready=1 returns the FSM to LOAD.
- HEIGHT=12 (NBYTES=2), bytes 8'hA5 then 8'hC0 → net_pixels=12'hA5C; no start pulse after the first byte; start follows the second byte.
- Back-to-back images with res_ready tied 1 → two results; the second image's pixels are fully replaced; each start is separated by at least 73+2 cycles.
